frame_writer: RTL and testbench
===============================

Name: frame_writer

Overview:
- Upstream neighbour of the double-buffered frame store.
- Accepts the ray marcher's in-order pixel stream through a valid/ready handshake and generates write_enable, write_addr and write_data for the back buffer.
- Holds off after each completed frame until the display signals a frame boundary, then issues the one-cycle swap_buffers pulse together with the first write of the next frame. This keeps the display from tearing.

Parameters:
- WIDTH, `COLOR_BITS, pixel colour width.
- H_PIXELS, `DISPLAY_WIDTH, pixels per row.
- V_PIXELS, `DISPLAY_HEIGHT, rows per frame.
- ADDR_LEN, `ADDR_BITS, write address width; must hold H_PIXELS*V_PIXELS-1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- pixel_valid  input  1  upstream pixel present.
- pixel_color  input  WIDTH  pixel colour, row-major order.
- pixel_ready  output  1  writer can accept a pixel this cycle.
- frame_sync  input  1  one-cycle pulse from display timing at start of vertical blank.
- write_enable  output  1  frame-store write strobe.
- write_addr  output  ADDR_LEN  frame-store write address.
- write_data  output  WIDTH  frame-store write data.
- swap_buffers  output  1  swap pulse to frame store.
- frame_done  output  1  one-cycle pulse when the last pixel of a frame is written.
- frame_count  output  8  completed frames, wraps 255->0.

Behaviour:
- Handshake: a pixel is accepted in any cycle where pixel_valid && pixel_ready.
- Write latency: write_enable, write_addr and write_data are registered and appear exactly 1 cycle after acceptance; no combinational path from inputs to outputs.
- Address: internal counter pix_addr starts at 0. It increments by 1 per accepted pixel. On accepting address DEPTH-1 (DEPTH = H_PIXELS*V_PIXELS), it returns to 0 and the frame completes.
- States:
  - FILL: pixel_ready=1. Accepting the pixel at DEPTH-1 -> WAIT_SYNC.
  - WAIT_SYNC: pixel_ready=0. frame_sync=1 -> ARMED. Other inputs are ignored.
  - ARMED: pixel_ready=1. The first accepted pixel is written with swap_buffers=1 in the same cycle as its write_enable (address 0) -> FILL.
- swap_buffers is never high without write_enable; it is high for exactly one cycle per frame, except for the first frame after reset.
- First frame after reset: the state is FILL and no swap is issued, because the frame store already writes the non-displayed buffer.
- frame_done is registered and high in the same cycle as the write of address DEPTH-1.
- frame_count increments in that same cycle.
- frame_sync in FILL or ARMED is ignored; it is not latched.
- frame_sync in the same cycle as acceptance of pixel DEPTH-1 is ignored; the next pulse is required.
- pixel_valid low in ARMED: the swap stays pending indefinitely until a pixel is accepted.
- Reset values: state=FILL, pix_addr=0, pixel_ready=1 from the first cycle after reset, write_enable=0, write_addr=0, write_data=0, swap_buffers=0, frame_done=0, frame_count=0.
- Reset mid-frame: partial frame abandoned; the next accepted pixel is written to address 0 with no swap.
- Reset has priority over every other input.

Optional Feature:
- Macro: FRAME_WRITER_STATS_EN.
- When defined: adds output stall_cycles (16 bits).
  - Counts cycles spent in WAIT_SYNC plus cycles in FILL/ARMED with pixel_valid=0, for the current frame. Saturates at 16'hFFFF.
  - Latched to the output in the frame_done cycle; the internal count clears in the same cycle. Reset value 0.
- When undefined: the port and logic are absent; all other behaviour is identical.

Test Plan (H_PIXELS=4, V_PIXELS=2):
- First frame: reset, then 8 back-to-back valid pixels with colours 1..8 -> writes to addr 0..7 one cycle after each accept; swap_buffers never high; frame_done with addr 7; frame_count=1.
- Sync hold-off: continue valid after frame 0 -> pixel_ready=0 until frame_sync; the next write is addr 0 with swap_buffers=1 for exactly that one cycle; the following writes have swap_buffers=0.
- Early/coincident sync: frame_sync pulsed in FILL and on the cycle pixel 7 is accepted -> ignored, still WAIT_SYNC; a later pulse -> ARMED.
- Bubbles: pixel_valid toggled 1,0,1,0 in ARMED -> swap accompanies only the first real write; addresses contiguous with no gaps.
- Reset mid-frame: after 5 pixels of frame 2, assert rst one cycle -> all outputs 0, frame_count=0; the next pixel is written to addr 0 with no swap.
- Wrap: 256 frames with a sync after each -> frame_count wraps to 0; (with FRAME_WRITER_STATS_EN) 3 sync-wait cycles give stall_cycles=3 at the next frame_done.

Source files
------------

// File: rtl/frame_writer.sv
// Frame-store writer: turns the in-order pixel stream into back-buffer writes and issues
// swap_buffers with the first write after a display frame boundary. FRAME_WRITER_STATS_EN adds stall_cycles.
module frame_writer #(
    parameter int WIDTH    = 8,
    parameter int H_PIXELS = 4,
    parameter int V_PIXELS = 2,
    parameter int ADDR_LEN = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pixel_valid,
    input  logic [WIDTH-1:0]    pixel_color,
    output logic                pixel_ready,
    input  logic                frame_sync,
    output logic                write_enable,
    output logic [ADDR_LEN-1:0] write_addr,
    output logic [WIDTH-1:0]    write_data,
    output logic                swap_buffers,
    output logic                frame_done,
`ifdef FRAME_WRITER_STATS_EN
    output logic [15:0]         stall_cycles,
`endif
    output logic [7:0]          frame_count
);

    localparam int                  DEPTH = H_PIXELS * V_PIXELS;
    localparam logic [ADDR_LEN-1:0] LAST  = ADDR_LEN'(DEPTH - 1);
    localparam logic [ADDR_LEN-1:0] ONE   = ADDR_LEN'(1);

    typedef enum logic [1:0] {FILL, WAIT_SYNC, ARMED} state_t;

    state_t              state_q, state_d;
    logic [ADDR_LEN-1:0] pix_addr_q, pix_addr_d;
    logic                accept, last;

    logic                we_q;
    logic [ADDR_LEN-1:0] addr_q;
    logic [WIDTH-1:0]    data_q;
    logic                swap_q, done_q;
    logic [7:0]          count_q;

    // Ready depends only on state, so there is no input-to-output combinational path.
    assign pixel_ready = (state_q != WAIT_SYNC);
    assign accept      = pixel_valid && pixel_ready;
    assign last        = (pix_addr_q == LAST);

    always_comb begin
        state_d    = state_q;
        pix_addr_d = pix_addr_q;
        if (accept)
            pix_addr_d = last ? '0 : pix_addr_q + ONE;
        case (state_q)
            FILL:      if (accept && last) state_d = WAIT_SYNC;
            WAIT_SYNC: if (frame_sync)     state_d = ARMED;
            ARMED:     if (accept)         state_d = last ? WAIT_SYNC : FILL;
            default:                       state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FILL;
            pix_addr_q <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            swap_q     <= 1'b0;
            done_q     <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pix_addr_q <= pix_addr_d;
            we_q       <= accept;
            swap_q     <= accept && (state_q == ARMED);
            done_q     <= accept && last;
            if (accept) begin
                addr_q <= pix_addr_q;
                data_q <= pixel_color;
            end
            if (accept && last)
                count_q <= count_q + 8'd1;
        end
    end

    assign write_enable = we_q;
    assign write_addr   = addr_q;
    assign write_data   = data_q;
    assign swap_buffers = swap_q;
    assign frame_done   = done_q;
    assign frame_count  = count_q;

`ifdef FRAME_WRITER_STATS_EN
    logic [15:0] stall_cnt_q, stall_q;
    logic        stall_now;

    // An accepting cycle is never a stall, so the frame's total is complete when latched.
    assign stall_now = (state_q == WAIT_SYNC) || !pixel_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            stall_q     <= '0;
        end else if (accept && last) begin
            stall_q     <= stall_cnt_q;
            stall_cnt_q <= '0;
        end else if (stall_now && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_frame_writer.sv
// Bench for frame_writer (4x2 frame): per-cycle frame-level model plus literal spot checks.
module tb_frame_writer;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst, pixel_valid, frame_sync;
    logic [7:0] pixel_color;
    logic       pixel_ready, write_enable, swap_buffers, frame_done;
    logic [2:0] write_addr;
    logic [7:0] write_data, frame_count;
`ifdef FRAME_WRITER_STATS_EN
    logic [15:0] stall_cycles;
`endif

    frame_writer #(.WIDTH(8), .H_PIXELS(4), .V_PIXELS(2), .ADDR_LEN(3)) dut (
        .clk(clk), .rst(rst), .pixel_valid(pixel_valid), .pixel_color(pixel_color),
        .pixel_ready(pixel_ready), .frame_sync(frame_sync), .write_enable(write_enable),
        .write_addr(write_addr), .write_data(write_data), .swap_buffers(swap_buffers),
        .frame_done(frame_done),
`ifdef FRAME_WRITER_STATS_EN
        .stall_cycles(stall_cycles),
`endif
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: pixels taken this frame, whether a display boundary is awaited,
    // and whether a swap is owed to the next write.
    bit         m_init = 0, m_blocked, m_swap_due, e_rst;
    int         m_cnt, m_frames, m_stall, e_stall;
    logic       e_we, e_swap, e_done;
    logic [2:0] e_addr;
    logic [7:0] e_data;

    initial begin
        forever begin
            @(negedge clk);
            if (m_init) begin
                chk("pixel_ready", pixel_ready, !m_blocked);
                chk("write_enable", write_enable, e_we);
                chk("swap_buffers", swap_buffers, e_swap);
                chk("frame_done", frame_done, e_done);
                chk("frame_count", frame_count, m_frames);
                if (e_we || e_rst) begin
                    chk("write_addr", write_addr, e_addr);
                    chk("write_data", write_data, e_data);
                end
`ifdef FRAME_WRITER_STATS_EN
                chk("stall_cycles", stall_cycles, e_stall);
`endif
            end
            if (rst) begin
                m_init = 1; e_rst = 1; m_blocked = 0; m_swap_due = 0;
                m_cnt = 0; m_frames = 0; m_stall = 0; e_stall = 0;
                e_we = 0; e_swap = 0; e_done = 0; e_addr = 0; e_data = 0;
            end else if (m_init) begin
                bit acc;
                e_rst = 0;
                acc = pixel_valid && !m_blocked;
                if ((m_blocked || !pixel_valid) && m_stall < 65535) m_stall++;
                e_we = acc; e_swap = 0; e_done = 0;
                if (m_blocked && frame_sync) m_blocked = 0;
                if (acc) begin
                    e_addr = m_cnt[2:0];
                    e_data = pixel_color;
                    e_swap = m_swap_due;
                    m_swap_due = 0;
                    if (m_cnt == DEPTH - 1) begin
                        e_done = 1; m_cnt = 0; m_frames = (m_frames + 1) % 256;
                        m_blocked = 1; m_swap_due = 1;
                        e_stall = m_stall; m_stall = 0;
                    end else begin
                        m_cnt++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push(input int c, input logic s);
        pixel_valid = 1; pixel_color = c[7:0]; frame_sync = s;
        tick();
        pixel_valid = 0; frame_sync = 0;
    endtask

    task automatic hold(input int n);
        pixel_valid = 1;
        repeat (n) tick();
        pixel_valid = 0;
    endtask

    task automatic sync_pulse();
        pixel_valid = 1; frame_sync = 1;
        tick();
        pixel_valid = 0; frame_sync = 0;
    endtask

    initial begin
        rst = 1; pixel_valid = 0; frame_sync = 0; pixel_color = 0;
        tick(); tick();
        rst = 0;
        chk("lit reset frame_count", frame_count, 0);
        chk("lit reset pixel_ready", pixel_ready, 1);
        chk("lit reset write_enable", write_enable, 0);

        // first frame, with frame_sync in FILL and on the last acceptance
        for (int i = 1; i <= 8; i++) push(i, (i == 3) || (i == 8));
        chk("lit f0 addr", write_addr, 7);
        chk("lit f0 data", write_data, 8);
        chk("lit f0 done", frame_done, 1);
        chk("lit f0 count", frame_count, 1);
        chk("lit f0 swap", swap_buffers, 0);

        hold(3);
        chk("lit wait ready", pixel_ready, 0);
        sync_pulse();
        chk("lit armed ready", pixel_ready, 1);
        push(9, 0);
        chk("lit swap write addr", write_addr, 0);
        chk("lit swap pulse", swap_buffers, 1);
        push(10, 1);
        chk("lit after swap", swap_buffers, 0);
        chk("lit after swap addr", write_addr, 1);
        for (int i = 11; i <= 16; i++) push(i, 0);
        chk("lit f1 count", frame_count, 2);

        // bubbles while armed
        sync_pulse();
        push(17, 0); tick(); push(18, 0);
        chk("lit bubble addr", write_addr, 1);
        chk("lit bubble swap", swap_buffers, 0);
        tick(); push(19, 0); push(20, 0); push(21, 0);

        // reset mid-frame
        rst = 1; tick(); rst = 0;
        chk("lit midrst count", frame_count, 0);
        chk("lit midrst we", write_enable, 0);
        push(8'h33, 0);
        chk("lit post-rst addr", write_addr, 0);
        chk("lit post-rst swap", swap_buffers, 0);
        for (int i = 0; i < 7; i++) push(8'h40 + i, 0);
        chk("lit post-rst count", frame_count, 1);

        // 255 more frames, each preceded by exactly 3 WAIT_SYNC cycles
        repeat (255) begin
            hold(2); sync_pulse();
            for (int i = 0; i < 8; i++) push(i * 3 + 1, 0);
        end
        chk("lit wrap count", frame_count, 0);
`ifdef FRAME_WRITER_STATS_EN
        chk("lit stall_cycles", stall_cycles, 3);
`endif
        tick(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
